// File: rtl/bus_sram_responder_pkg.sv
// bus_sram_responder shared definitions.
// Sequencer state encoding and strobe-width legal range.
package bus_sram_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } sram_state_t;

    localparam int WAIT_STATES_MIN = 1;
    localparam int WAIT_STATES_MAX = 15;

endpackage

// File: rtl/bus_sram_responder_if.sv
// Request/ready memory bus between a requester and the SRAM responder.
// master drives request/rw/address/wdata; slave returns ready/rdata.
interface bus_sram_responder_if;

    logic        i_request;
    logic        i_rw;
    logic [31:0] i_address;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic [31:0] o_rdata;

    modport master (
        output i_request, i_rw, i_address, i_wdata,
        input  o_ready, o_rdata
    );

    modport slave (
        input  i_request, i_rw, i_address, i_wdata,
        output o_ready, o_rdata
    );

endinterface

// File: rtl/bus_sram_responder.sv
// Serves 32-bit bus accesses as two 16-bit async SRAM cycles, low half first.
// Ports: i_clock, i_reset (async, active-low), bus (slave modport),
//   o_sram_address/ce_n/oe_n/we_n/wdata/data_oe out, i_sram_rdata in.
module bus_sram_responder #(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_WIDTH  = 18
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    bus_sram_responder_if.slave   bus,
    output logic [ADDR_WIDTH-1:0] o_sram_address,
    output logic                  o_sram_ce_n,
    output logic                  o_sram_oe_n,
    output logic                  o_sram_we_n,
    output logic [15:0]           o_sram_wdata,
    output logic                  o_sram_data_oe,
    input  logic [15:0]           i_sram_rdata
);
    import bus_sram_responder_pkg::*;

    localparam logic [3:0] WaitLoad = 4'(WAIT_STATES - 1);

    sram_state_t           state;
    sram_state_t           state_next;
    logic                  rw_q;
    logic                  half;
    logic                  ready_q;
    logic                  accept;
    logic [ADDR_WIDTH-2:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rbuf_q;
    logic [31:0]           rdata_q;
    logic [3:0]            wait_cnt;
    logic                  unused_addr_bits;

    // Ready is still high on the edge after completion; a request held
    // across that edge must not start a second access.
    assign accept = bus.i_request && !ready_q;

    assign unused_addr_bits = ^{bus.i_address[31:ADDR_WIDTH+1],
                                bus.i_address[1:0]};

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   if (accept) state_next = SETUP;
            SETUP:  state_next = STROBE;
            STROBE: if (wait_cnt == 4'd0) state_next = HOLD;
            HOLD:   state_next = half ? IDLE : SETUP;
        endcase
    end

    always_comb begin
        o_sram_ce_n    = 1'b1;
        o_sram_oe_n    = 1'b1;
        o_sram_we_n    = 1'b1;
        o_sram_data_oe = 1'b0;
        unique case (state)
            IDLE: ;
            SETUP, HOLD: begin
                o_sram_ce_n    = 1'b0;
                o_sram_data_oe = rw_q;
            end
            STROBE: begin
                o_sram_ce_n    = 1'b0;
                o_sram_data_oe = rw_q;
                o_sram_oe_n    = rw_q;
                o_sram_we_n    = !rw_q;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rw_q     <= 1'b0;
            half     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rbuf_q   <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            ready_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        rw_q    <= bus.i_rw;
                        addr_q  <= bus.i_address[ADDR_WIDTH:2];
                        wdata_q <= bus.i_wdata;
                        half    <= 1'b0;
                    end
                end
                SETUP: wait_cnt <= WaitLoad;
                STROBE: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else if (!rw_q) begin
                        if (half) rbuf_q[31:16] <= i_sram_rdata;
                        else      rbuf_q[15:0]  <= i_sram_rdata;
                    end
                end
                HOLD: begin
                    if (!half) begin
                        half <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                        if (!rw_q) rdata_q <= rbuf_q;
                    end
                end
            endcase
        end
    end

    assign o_sram_address = {addr_q, half};
    assign o_sram_wdata   = half ? wdata_q[31:16] : wdata_q[15:0];
    assign bus.o_ready    = ready_q;
    assign bus.o_rdata    = rdata_q;

endmodule

// File: tb/tb_bus_sram_responder.sv
// Bench for bus_sram_responder: WAIT_STATES=2 and =1 instances,
// transaction-level reference model, SRAM model and per-cycle compare.
module tb_bus_sram_responder;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    logic        req   [2];
    logic        rw    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        rdy   [2];
    logic [31:0] rdata [2];
    logic [17:0] sa    [2];
    logic        ce    [2];
    logic        oe    [2];
    logic        we    [2];
    logic        doe   [2];
    logic [15:0] swd   [2];
    logic [15:0] srd   [2];

    logic [15:0] sram [2][0:262143];
    logic [31:0] refm [2][0:131071];

    function automatic int ws(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bus_sram_responder_if u_bus ();
        assign u_bus.i_request = req[g];
        assign u_bus.i_rw      = rw[g];
        assign u_bus.i_address = addr[g];
        assign u_bus.i_wdata   = wdata[g];
        assign rdy[g]          = u_bus.o_ready;
        assign rdata[g]        = u_bus.o_rdata;
        bus_sram_responder #(
            .WAIT_STATES (g == 0 ? 2 : 1),
            .ADDR_WIDTH  (18)
        ) u_dut (
            .i_clock        (clk),
            .i_reset        (rst_n),
            .bus            (u_bus.slave),
            .o_sram_address (sa[g]),
            .o_sram_ce_n    (ce[g]),
            .o_sram_oe_n    (oe[g]),
            .o_sram_we_n    (we[g]),
            .o_sram_wdata   (swd[g]),
            .o_sram_data_oe (doe[g]),
            .i_sram_rdata   (srd[g])
        );
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Asynchronous SRAM: data latched when we_n rises, read while oe_n low.
    logic p_we [2];
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                p_we[k] = 1'b1;
            end else begin
                if (!p_we[k] && we[k]) sram[k][sa[k]] = swd[k];
                p_we[k] = we[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            srd[k] = oe[k] ? 16'hA5A5 : sram[k][sa[k]];
        end
    end

    // Transaction-level model: accept when idle, requested and no ready
    // pulse pending; completion 2*WS+4 edges later.
    logic        m_busy  [2];
    logic        m_rdy   [2];
    logic        m_wr    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wd    [2];
    logic [31:0] m_rdata [2];
    int          m_cnt   [2];
    logic        p_rdy;
    logic        p_busy;
    logic [16:0] m_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k]  = 1'b0;
                m_rdy[k]   = 1'b0;
                m_rdata[k] = '0;
                m_cnt[k]   = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                p_rdy    = m_rdy[k];
                p_busy   = m_busy[k];
                m_rdy[k] = 1'b0;
                if (m_busy[k]) begin
                    m_cnt[k]--;
                    if (m_cnt[k] == 0) begin
                        m_busy[k] = 1'b0;
                        m_rdy[k]  = 1'b1;
                        m_idx     = m_addr[k][18:2];
                        if (m_wr[k]) refm[k][m_idx] = m_wd[k];
                        else         m_rdata[k] = refm[k][m_idx];
                    end
                end
                if (!p_busy && !p_rdy && req[k]) begin
                    m_busy[k] = 1'b1;
                    m_cnt[k]  = 2 * ws(k) + 4;
                    m_wr[k]   = rw[k];
                    m_addr[k] = addr[k];
                    m_wd[k]   = wdata[k];
                end
            end
        end
    end

    logic        p_low [2];
    logic [17:0] p_sa  [2];
    logic [15:0] p_swd [2];
    int          run   [2];
    int          nstr  [2];
    logic        lowv;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                p_low[k] = 1'b0;
                p_sa[k]  = '0;
                p_swd[k] = '0;
                run[k]   = 0;
                nstr[k]  = 0;
            end else begin
                lowv = !oe[k] || !we[k];
                chk("ready", rdy[k], m_rdy[k]);
                chk("rdata", rdata[k], m_rdata[k]);
                chk("ce_n", ce[k], !m_busy[k]);
                chk("data_oe", doe[k], m_busy[k] && m_wr[k]);
                chk("oe_kind", !oe[k] && (m_wr[k] || !m_busy[k]), 0);
                chk("we_kind", !we[k] && !(m_wr[k] && m_busy[k]), 0);
                if (lowv != p_low[k]) begin
                    chk("addr_vs_strobe", sa[k], p_sa[k]);
                    chk("wdata_vs_strobe", swd[k], p_swd[k]);
                    if (lowv) begin
                        chk("sram_addr", sa[k],
                            {m_addr[k][18:2], nstr[k][0]});
                        nstr[k]++;
                        run[k] = 0;
                    end else begin
                        chk("strobe_width", run[k], ws(k));
                    end
                end
                if (lowv) run[k]++;
                if (m_rdy[k]) begin
                    chk("strobes", nstr[k], 2);
                    nstr[k] = 0;
                    if (m_wr[k]) begin
                        chk("sram_lo", sram[k][{m_addr[k][18:2], 1'b0}],
                            m_wd[k][15:0]);
                        chk("sram_hi", sram[k][{m_addr[k][18:2], 1'b1}],
                            m_wd[k][31:16]);
                    end
                end
                p_low[k] = lowv;
                p_sa[k]  = sa[k];
                p_swd[k] = swd[k];
            end
        end
    end

    task automatic wait_ready(input int k, output bit ok);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[k] && n < 200);
        ok = rdy[k];
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL timeout: no ready on port %0d", k);
        end
    endtask

    task automatic access(input int k, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input int lat);
        int c0;
        bit ok;
        @(posedge clk);
        #1;
        req[k]   = 1'b1;
        rw[k]    = w;
        addr[k]  = a;
        wdata[k] = d;
        c0       = cyc;
        wait_ready(k, ok);
        if (ok && lat >= 0) chk("latency", cyc - c0 - 1, lat);
        @(posedge clk);
        #1;
        req[k] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        bit ok;
        logic [31:0] a;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 262144; i++) sram[k][i] = '0;
            for (int i = 0; i < 131072; i++) refm[k][i] = '0;
            req[k]   = 1'b0;
            rw[k]    = 1'b0;
            addr[k]  = '0;
            wdata[k] = '0;
        end

        #3 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", rdy[k], 0);
            chk("rst_rdata", rdata[k], 0);
            chk("rst_addr", sa[k], 0);
            chk("rst_wdata", swd[k], 0);
            chk("rst_strobes", {ce[k], oe[k], we[k], doe[k]}, 4'b1110);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        access(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 8);
        chk("hw8", sram[0][8], 16'hBEEF);
        chk("hw9", sram[0][9], 16'hDEAD);
        access(0, 1'b0, 32'h0000_0010, 32'h0, 8);
        chk("read_10", rdata[0], 32'hDEAD_BEEF);

        repeat (4) begin
            @(negedge clk);
            chk("no_restart", ce[0], 1'b1);
        end

        access(0, 1'b0, 32'h0010_0010, 32'h0, 8);
        chk("alias_hi", rdata[0], 32'hDEAD_BEEF);
        access(0, 1'b0, 32'h0000_0013, 32'h0, 8);
        chk("alias_lo", rdata[0], 32'hDEAD_BEEF);

        @(posedge clk);
        #1;
        req[0]   = 1'b1;
        rw[0]    = 1'b1;
        addr[0]  = 32'h0000_0020;
        wdata[0] = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        #1 req[0] = 1'b0;
        wait_ready(0, ok);
        access(0, 1'b0, 32'h0000_0020, 32'h0, 8);
        chk("dropped_req_write", rdata[0], 32'hCAFE_F00D);

        @(posedge clk);
        #1;
        req[0]   = 1'b1;
        rw[0]    = 1'b1;
        addr[0]  = 32'h0000_0010;
        wdata[0] = 32'hDEAD_BEEF;
        for (int n = 0; n < 20 && we[0]; n++) @(negedge clk);
        chk("reached_strobe", we[0], 1'b0);
        #2;
        rst_n  = 1'b0;
        req[0] = 1'b0;
        #1;
        chk("async_rst_we", we[0], 1'b1);
        chk("async_rst_ce", ce[0], 1'b1);
        chk("async_rst_doe", doe[0], 1'b0);
        chk("async_rst_addr", sa[0], 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        access(0, 1'b0, 32'h0000_0010, 32'h0, 8);
        chk("read_after_rst", rdata[0], 32'hDEAD_BEEF);

        access(1, 1'b1, 32'h0000_0004, 32'h1234_5678, 6);
        chk("ws1_hw2", sram[1][2], 16'h5678);
        chk("ws1_hw3", sram[1][3], 16'h1234);
        access(1, 1'b0, 32'h0000_0004, 32'h0, 6);
        chk("ws1_read", rdata[1], 32'h1234_5678);

        for (int i = 0; i < 60; i++) begin
            a = ($urandom & 32'hFFF8_0000)
              | (32'($urandom_range(0, 15)) << 2)
              | 32'($urandom_range(0, 3));
            access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   a, $urandom, -1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_sram_responder.md
# bus_sram_responder

Bus responder that terminates the request/ready memory bus driven by the cache, bus bridges and CPU, and serves each 32-bit access from an external asynchronous 16-bit SRAM. Every word access becomes two halfword SRAM cycles, low half first, with programmable strobe width. Sits at the leaf of the bus fabric, below the L2 cache, as the backing store for main memory.

## Interface
- WAIT_STATES, 2, SRAM strobe width in clock cycles (oe_n/we_n low time per halfword); legal range 1..15.
- ADDR_WIDTH, 18, SRAM halfword address width.
- i_clock  in  1  single clock for the whole block.
- i_reset  in  1  asynchronous, active-low reset.
- i_request  in  1  bus request; held with address/rw/wdata stable until o_ready is seen.
- i_rw  in  1  0 = read, 1 = write.
- i_address  in  32  byte address; [1:0] ignored, [ADDR_WIDTH:2] used, upper bits ignored (aliasing).
- i_wdata  in  32  write data.
- o_ready  out  1  one-cycle completion pulse.
- o_rdata  out  32  read data, valid while o_ready is high; held until the next read completes.
- o_sram_address  out  ADDR_WIDTH  halfword address {i_address[ADDR_WIDTH:2], half}.
- o_sram_ce_n / o_sram_oe_n / o_sram_we_n  out  1 each  active-low SRAM strobes.
- o_sram_wdata  out  16  halfword write data.
- o_sram_data_oe  out  1  tri-state enable for the top-level SRAM data pad.
- i_sram_rdata  in  16  SRAM data pad input.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, with a `half` flag (0 = low halfword, 1 = high halfword) and a 4-bit wait counter.
- IDLE:
  - Accepts a request when i_request=1 and o_ready=0 (registered). This guard stops a request still high during the ready pulse from starting a second access.
  - On accept: latch rw, address and wdata; half=0; go to SETUP.
- SETUP (1 cycle):
  - ce_n=0 and address driven.
  - Write: data_oe=1 and wdata = low/high halfword of the latched data.
  - oe_n and we_n stay high.
- STROBE (WAIT_STATES cycles):
  - Read: oe_n=0. Write: we_n=0.
  - Counter loads WAIT_STATES-1 on entry and decrements to 0.
  - Read: i_sram_rdata is sampled into the low or high halfword of an internal register on the edge leaving STROBE.
- HOLD (1 cycle):
  - oe_n and we_n high. ce_n, address and write data stay stable (write data hold time).
  - If half=0: set half=1 and go to SETUP.
  - If half=1: o_ready<=1; on a read, o_rdata <= assembled word; go to IDLE with ce_n and data_oe deasserted.
- o_ready is forced to 0 on the next edge after it rises.
- Write data mapping: halfword 2n = wdata[15:0], halfword 2n+1 = wdata[31:16]. Reads assemble the same way.
- If the requester drops i_request mid-access (protocol violation), the access still completes and o_ready still pulses.

## Timing
- Accept edge is E0. o_ready rises at E0 + 2·WAIT_STATES + 4, which is E8 at the default setting. Read and write latency are identical.
- Throughput: back-to-back requests are accepted no earlier than 2 edges after o_ready rises (requester drops request, then re-raises it).
- we_n and oe_n never change on the same edge as o_sram_address or o_sram_wdata. Address and data always have ≥1 cycle of setup and ≥1 cycle of hold around each strobe.
- o_sram_data_oe is high only in SETUP/STROBE/HOLD of writes and is never high while oe_n=0.
- Asynchronous reset (i_reset=0), at any time including mid-strobe, takes effect immediately without waiting for a clock edge. It forces:
  - state IDLE, half 0;
  - o_ready 0, o_rdata 0;
  - o_sram_address 0, o_sram_wdata 0;
  - ce_n/oe_n/we_n 1, data_oe 0.
- An interrupted transaction is abandoned with no ready pulse. The first accept is possible at the first edge after reset deassertion.

## Structure
- The shared defines package holds the state enum `sram_state_t` (IDLE, SETUP, STROBE, HOLD) and the WAIT_STATES legal-range constants.
- A single module with no sub-module. The sequencer, wait counter and data assembly are small enough to stay inline.
- Tri-state pad instantiation belongs to the top level, not this block.

## Test plan
- Write 0x0000_0010 / 0xDEAD_BEEF, WAIT_STATES=2 -> SRAM model halfword 8 = 0xBEEF, halfword 9 = 0xDEAD; we_n low exactly 2 cycles per half; o_ready high one cycle at E8.
- Read 0x0000_0010 after the write -> o_rdata = 0xDEAD_BEEF at E8; oe_n low 2 cycles per half; data_oe stays 0 throughout.
- Requester holds i_request high through the edge after o_ready -> no second SRAM cycle starts. After a drop and re-raise, exactly one new access occurs with one ready pulse.
- i_reset pulled low during STROBE of a write -> we_n, ce_n and data_oe go inactive before the next edge; no ready pulse; after release, a read of 0x10 completes normally at E8.
- Read 0x0010_0010 (ADDR_WIDTH=18) -> SRAM addresses 8 then 9, same data as 0x10 (upper-bit aliasing); i_address[1:0]=3 gives the same result.
- WAIT_STATES=1 build, write then read of 0x0000_0004 / 0x1234_5678 -> ready at E6 for both; halfwords 2/3 = 0x5678/0x1234; read returns 0x1234_5678.
